// File: rtl/sad_min_pkg.sv
// Shared lane geometry, motion-vector widths and FSM encoding for the
// SAD minimum-select block.
package sad_min_pkg;

   // SAD lane widths per partition size
   localparam int W_8X8   = 14;
   localparam int W_8X16  = 15;
   localparam int W_16X8  = 15;
   localparam int W_16X16 = 16;
   localparam int W_16X32 = 17;
   localparam int W_32X16 = 17;
   localparam int W_32X32 = 18;

   // Lane counts per partition size
   localparam int N_8X8   = 16;
   localparam int N_8X16  = 8;
   localparam int N_16X8  = 8;
   localparam int N_16X16 = 4;
   localparam int N_16X32 = 2;
   localparam int N_32X16 = 2;
   localparam int N_32X32 = 1;

   // Motion-vector component widths
   localparam int COL_W = 5;
   localparam int ROW_W = 7;

   // Position of each partition group inside the 41-lane MV buses
   localparam int OFS_8X8   = 0;
   localparam int OFS_8X16  = OFS_8X8  + N_8X8;
   localparam int OFS_16X8  = OFS_8X16 + N_8X16;
   localparam int OFS_16X16 = OFS_16X8 + N_16X8;
   localparam int OFS_16X32 = OFS_16X16 + N_16X16;
   localparam int OFS_32X16 = OFS_16X32 + N_16X32;
   localparam int OFS_32X32 = OFS_32X16 + N_32X16;
   localparam int N_LANES   = OFS_32X32 + N_32X32;

   // Search controller states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/sad_min_lane.sv
// One running-minimum lane: holds the smallest SAD seen so far and the
// search position (col,row) where it was found.
module sad_min_lane
   import sad_min_pkg::*;
#(
   parameter int W = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init,
   input  logic             update,
   input  logic [W-1:0]     sad,
   input  logic [COL_W-1:0] col,
   input  logic [ROW_W-1:0] row,
   output logic [W-1:0]     min_sad,
   output logic [COL_W-1:0] min_col,
   output logic [ROW_W-1:0] min_row
);

   // Reset/init to the worst possible SAD; a strictly smaller sample wins,
   // so on ties the earlier position is kept.
   always_ff @(posedge clk) begin
      if (!rst_n || init) begin
         min_sad <= '1;
         min_col <= '0;
         min_row <= '0;
      end else if (update && (sad < min_sad)) begin
         min_sad <= sad;
         min_col <= col;
         min_row <= row;
      end
   end

endmodule

// File: rtl/sad_min_select.sv
// Tracks, for all 41 partition lanes independently, the minimum SAD and
// its search position over one search, and flags completion.
module sad_min_select
   import sad_min_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         search_start,
   input  logic                         sad_valid,
   input  logic                         sad_last,
   input  logic [COL_W-1:0]             search_column_count,
   input  logic [ROW_W-1:0]             search_row_count,
   input  logic [N_8X8*W_8X8-1:0]       SAD8x8,
   input  logic [N_8X16*W_8X16-1:0]     SAD8x16,
   input  logic [N_16X8*W_16X8-1:0]     SAD16x8,
   input  logic [N_16X16*W_16X16-1:0]   SAD16x16,
   input  logic [N_16X32*W_16X32-1:0]   SAD16x32,
   input  logic [N_32X16*W_32X16-1:0]   SAD32x16,
   input  logic [N_32X32*W_32X32-1:0]   SAD32x32,
   output logic [N_8X8*W_8X8-1:0]       best_sad8x8,
   output logic [N_8X16*W_8X16-1:0]     best_sad8x16,
   output logic [N_16X8*W_16X8-1:0]     best_sad16x8,
   output logic [N_16X16*W_16X16-1:0]   best_sad16x16,
   output logic [N_16X32*W_16X32-1:0]   best_sad16x32,
   output logic [N_32X16*W_32X16-1:0]   best_sad32x16,
   output logic [N_32X32*W_32X32-1:0]   best_sad32x32,
   output logic [N_LANES*COL_W-1:0]     best_col,
   output logic [N_LANES*ROW_W-1:0]     best_row,
   output logic                         result_valid,
   output logic                         busy
);

   state_t state;
   logic   sample_en;

   // A start pulse wins over a coincident sample: the sample is dropped.
   assign sample_en = (state == ST_SEARCH) && sad_valid && !search_start;

   // Search controller with registered busy / result_valid
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         busy         <= 1'b0;
         result_valid <= 1'b0;
      end else if (search_start) begin
         state        <= ST_SEARCH;
         busy         <= 1'b1;
         result_valid <= 1'b0;
      end else begin
         case (state)
            ST_SEARCH: begin
               if (sad_valid && sad_last) begin
                  state        <= ST_DONE;
                  busy         <= 1'b0;
                  result_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               state        <= ST_IDLE;
               busy         <= 1'b0;
               result_valid <= 1'b0;
            end
            ST_IDLE: begin
               busy         <= 1'b0;
               result_valid <= 1'b0;
            end
            default: begin
               state        <= ST_IDLE;
               busy         <= 1'b0;
               result_valid <= 1'b0;
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < N_8X8; gi++) begin : g_8x8
      sad_min_lane #(.W(W_8X8)) u_lane (
         .clk(clk), .rst_n(rst_n), .init(search_start), .update(sample_en),
         .sad(SAD8x8[gi*W_8X8 +: W_8X8]),
         .col(search_column_count), .row(search_row_count),
         .min_sad(best_sad8x8[gi*W_8X8 +: W_8X8]),
         .min_col(best_col[(OFS_8X8+gi)*COL_W +: COL_W]),
         .min_row(best_row[(OFS_8X8+gi)*ROW_W +: ROW_W])
      );
   end

   for (genvar gi = 0; gi < N_8X16; gi++) begin : g_8x16
      sad_min_lane #(.W(W_8X16)) u_lane (
         .clk(clk), .rst_n(rst_n), .init(search_start), .update(sample_en),
         .sad(SAD8x16[gi*W_8X16 +: W_8X16]),
         .col(search_column_count), .row(search_row_count),
         .min_sad(best_sad8x16[gi*W_8X16 +: W_8X16]),
         .min_col(best_col[(OFS_8X16+gi)*COL_W +: COL_W]),
         .min_row(best_row[(OFS_8X16+gi)*ROW_W +: ROW_W])
      );
   end

   for (genvar gi = 0; gi < N_16X8; gi++) begin : g_16x8
      sad_min_lane #(.W(W_16X8)) u_lane (
         .clk(clk), .rst_n(rst_n), .init(search_start), .update(sample_en),
         .sad(SAD16x8[gi*W_16X8 +: W_16X8]),
         .col(search_column_count), .row(search_row_count),
         .min_sad(best_sad16x8[gi*W_16X8 +: W_16X8]),
         .min_col(best_col[(OFS_16X8+gi)*COL_W +: COL_W]),
         .min_row(best_row[(OFS_16X8+gi)*ROW_W +: ROW_W])
      );
   end

   for (genvar gi = 0; gi < N_16X16; gi++) begin : g_16x16
      sad_min_lane #(.W(W_16X16)) u_lane (
         .clk(clk), .rst_n(rst_n), .init(search_start), .update(sample_en),
         .sad(SAD16x16[gi*W_16X16 +: W_16X16]),
         .col(search_column_count), .row(search_row_count),
         .min_sad(best_sad16x16[gi*W_16X16 +: W_16X16]),
         .min_col(best_col[(OFS_16X16+gi)*COL_W +: COL_W]),
         .min_row(best_row[(OFS_16X16+gi)*ROW_W +: ROW_W])
      );
   end

   for (genvar gi = 0; gi < N_16X32; gi++) begin : g_16x32
      sad_min_lane #(.W(W_16X32)) u_lane (
         .clk(clk), .rst_n(rst_n), .init(search_start), .update(sample_en),
         .sad(SAD16x32[gi*W_16X32 +: W_16X32]),
         .col(search_column_count), .row(search_row_count),
         .min_sad(best_sad16x32[gi*W_16X32 +: W_16X32]),
         .min_col(best_col[(OFS_16X32+gi)*COL_W +: COL_W]),
         .min_row(best_row[(OFS_16X32+gi)*ROW_W +: ROW_W])
      );
   end

   for (genvar gi = 0; gi < N_32X16; gi++) begin : g_32x16
      sad_min_lane #(.W(W_32X16)) u_lane (
         .clk(clk), .rst_n(rst_n), .init(search_start), .update(sample_en),
         .sad(SAD32x16[gi*W_32X16 +: W_32X16]),
         .col(search_column_count), .row(search_row_count),
         .min_sad(best_sad32x16[gi*W_32X16 +: W_32X16]),
         .min_col(best_col[(OFS_32X16+gi)*COL_W +: COL_W]),
         .min_row(best_row[(OFS_32X16+gi)*ROW_W +: ROW_W])
      );
   end

   for (genvar gi = 0; gi < N_32X32; gi++) begin : g_32x32
      sad_min_lane #(.W(W_32X32)) u_lane (
         .clk(clk), .rst_n(rst_n), .init(search_start), .update(sample_en),
         .sad(SAD32x32[gi*W_32X32 +: W_32X32]),
         .col(search_column_count), .row(search_row_count),
         .min_sad(best_sad32x32[gi*W_32X32 +: W_32X32]),
         .min_col(best_col[(OFS_32X32+gi)*COL_W +: COL_W]),
         .min_row(best_row[(OFS_32X32+gi)*ROW_W +: ROW_W])
      );
   end

endmodule

// File: tb/tb_sad_min_select.sv
// Directed bench for sad_min_select: a per-cycle vector table on the 32x32
// lane plus hand-written all-lane sequences.
module tb_sad_min_select;

   logic          clk;
   logic          rst_n;
   logic          search_start;
   logic          sad_valid;
   logic          sad_last;
   logic [4:0]    search_column_count;
   logic [6:0]    search_row_count;
   logic [223:0]  SAD8x8;
   logic [119:0]  SAD8x16;
   logic [119:0]  SAD16x8;
   logic [63:0]   SAD16x16;
   logic [33:0]   SAD16x32;
   logic [33:0]   SAD32x16;
   logic [17:0]   SAD32x32;
   logic [223:0]  best_sad8x8;
   logic [119:0]  best_sad8x16;
   logic [119:0]  best_sad16x8;
   logic [63:0]   best_sad16x16;
   logic [33:0]   best_sad16x32;
   logic [33:0]   best_sad32x16;
   logic [17:0]   best_sad32x32;
   logic [204:0]  best_col;
   logic [286:0]  best_row;
   logic          result_valid;
   logic          busy;

   sad_min_select dut (
      .clk(clk), .rst_n(rst_n), .search_start(search_start),
      .sad_valid(sad_valid), .sad_last(sad_last),
      .search_column_count(search_column_count),
      .search_row_count(search_row_count),
      .SAD8x8(SAD8x8), .SAD8x16(SAD8x16), .SAD16x8(SAD16x8),
      .SAD16x16(SAD16x16), .SAD16x32(SAD16x32), .SAD32x16(SAD32x16),
      .SAD32x32(SAD32x32),
      .best_sad8x8(best_sad8x8), .best_sad8x16(best_sad8x16),
      .best_sad16x8(best_sad16x8), .best_sad16x16(best_sad16x16),
      .best_sad16x32(best_sad16x32), .best_sad32x16(best_sad32x16),
      .best_sad32x32(best_sad32x32),
      .best_col(best_col), .best_row(best_row),
      .result_valid(result_valid), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Per-lane stimulus and expected minima (global lane order 0..40)
   int v[41];
   int exp_s[41];
   int exp_c[41];
   int exp_r[41];

   typedef struct {
      bit rst_n, start, valid, last;
      int col, row, sad;
      int e_sad, e_col, e_row;
      bit e_rv, e_busy;
   } vec_t;
   vec_t vecs[$];

   function automatic int lane_w(int i);
      if (i < 16) return 14;
      if (i < 32) return 15;
      if (i < 36) return 16;
      if (i < 40) return 17;
      return 18;
   endfunction

   function automatic int ones(int i);
      return (1 << lane_w(i)) - 1;
   endfunction

   function automatic int got_sad(int i);
      if (i < 16) return int'(best_sad8x8[i*14 +: 14]);
      if (i < 24) return int'(best_sad8x16[(i-16)*15 +: 15]);
      if (i < 32) return int'(best_sad16x8[(i-24)*15 +: 15]);
      if (i < 36) return int'(best_sad16x16[(i-32)*16 +: 16]);
      if (i < 38) return int'(best_sad16x32[(i-36)*17 +: 17]);
      if (i < 40) return int'(best_sad32x16[(i-38)*17 +: 17]);
      return int'(best_sad32x32);
   endfunction

   task automatic check(string name, int got, int want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   // Drive one cycle of inputs from v[], clock once, settle past the edge
   task automatic drive(bit r, bit s, bit val, bit lst, int c, int rw);
      rst_n = r;
      search_start = s;
      sad_valid = val;
      sad_last = lst;
      search_column_count = c[4:0];
      search_row_count = rw[6:0];
      for (int i = 0; i < 16; i++) SAD8x8[i*14 +: 14] = v[i][13:0];
      for (int i = 0; i < 8; i++) begin
         SAD8x16[i*15 +: 15] = v[16+i][14:0];
         SAD16x8[i*15 +: 15] = v[24+i][14:0];
      end
      for (int i = 0; i < 4; i++) SAD16x16[i*16 +: 16] = v[32+i][15:0];
      for (int i = 0; i < 2; i++) begin
         SAD16x32[i*17 +: 17] = v[36+i][16:0];
         SAD32x16[i*17 +: 17] = v[38+i][16:0];
      end
      SAD32x32 = v[40][17:0];
      @(posedge clk);
      #1;
   endtask

   task automatic fill_ones();
      for (int i = 0; i < 41; i++) v[i] = ones(i);
   endtask

   task automatic exp_reset();
      for (int i = 0; i < 41; i++) begin
         exp_s[i] = ones(i);
         exp_c[i] = 0;
         exp_r[i] = 0;
      end
   endtask

   task automatic check_all(string tag);
      for (int i = 0; i < 41; i++) begin
         check($sformatf("%s lane%0d sad", tag, i), got_sad(i), exp_s[i]);
         check($sformatf("%s lane%0d col", tag, i), int'(best_col[i*5 +: 5]), exp_c[i]);
         check($sformatf("%s lane%0d row", tag, i), int'(best_row[i*7 +: 7]), exp_r[i]);
      end
   endtask

   task automatic add(bit r, bit s, bit val, bit lst, int c, int rw, int sd,
                      int es, int ec, int er, bit erv, bit eb);
      vec_t t;
      t.rst_n = r; t.start = s; t.valid = val; t.last = lst;
      t.col = c; t.row = rw; t.sad = sd;
      t.e_sad = es; t.e_col = ec; t.e_row = er; t.e_rv = erv; t.e_busy = eb;
      vecs.push_back(t);
   endtask

   localparam int ONES18 = 18'h3FFFF;

   initial begin
      rst_n = 1'b0;
      search_start = 1'b0;
      sad_valid = 1'b0;
      sad_last = 1'b0;
      search_column_count = '0;
      search_row_count = '0;
      fill_ones();
      SAD8x8 = '1; SAD8x16 = '1; SAD16x8 = '1; SAD16x16 = '1;
      SAD16x32 = '1; SAD32x16 = '1; SAD32x32 = '1;

      //   rst st vl ls col row sad     e_sad   ecol erow rv busy
      add(0, 0, 0, 0, 0, 0, 0,         ONES18, 0, 0, 0, 0);  // reset
      add(1, 0, 1, 0, 0, 0, 5,         ONES18, 0, 0, 0, 0);  // idle sample ignored
      add(1, 1, 0, 0, 0, 0, 0,         ONES18, 0, 0, 0, 1);  // start
      add(1, 0, 1, 0, 0, 0, 500,       500,    0, 0, 0, 1);
      add(1, 0, 1, 0, 1, 0, 300,       300,    1, 0, 0, 1);
      add(1, 0, 1, 1, 2, 0, 300,       300,    1, 0, 1, 0);  // tie kept, DONE
      add(1, 0, 1, 0, 3, 0, 7,         300,    1, 0, 0, 0);  // DONE sample ignored
      add(1, 0, 1, 0, 3, 0, 7,         300,    1, 0, 0, 0);  // held in IDLE
      add(1, 1, 1, 0, 0, 0, 1,         ONES18, 0, 0, 0, 1);  // start wins over sample
      add(1, 0, 1, 1, 4, 4, 200,       200,    4, 4, 1, 0);
      add(1, 0, 0, 0, 0, 0, 0,         200,    4, 4, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0,         ONES18, 0, 0, 0, 1);
      add(1, 0, 1, 0, 1, 1, 100,       100,    1, 1, 0, 1);
      add(1, 0, 1, 0, 2, 2, 50,        50,     2, 2, 0, 1);
      add(1, 1, 0, 0, 0, 0, 0,         ONES18, 0, 0, 0, 1);  // restart, no result
      add(1, 0, 1, 1, 3, 3, 900,       900,    3, 3, 1, 0);
      add(1, 0, 0, 0, 0, 0, 0,         900,    3, 3, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0,         ONES18, 0, 0, 0, 1);
      add(1, 0, 1, 0, 5, 6, 10,        10,     5, 6, 0, 1);
      add(0, 0, 1, 0, 6, 6, 5,         ONES18, 0, 0, 0, 0);  // reset mid-search
      add(1, 0, 1, 1, 7, 7, 3,         ONES18, 0, 0, 0, 0);  // IDLE after reset
      add(1, 1, 0, 0, 0, 0, 0,         ONES18, 0, 0, 0, 1);
      add(1, 0, 0, 1, 7, 7, 3,         ONES18, 0, 0, 0, 1);  // last w/o valid ignored
      add(1, 0, 1, 1, 9, 9, ONES18,    ONES18, 0, 0, 1, 0);  // equal to init: no update
      add(1, 0, 0, 0, 0, 0, 0,         ONES18, 0, 0, 0, 0);

      foreach (vecs[k]) begin
         fill_ones();
         v[40] = vecs[k].sad;
         drive(vecs[k].rst_n, vecs[k].start, vecs[k].valid, vecs[k].last,
               vecs[k].col, vecs[k].row);
         check($sformatf("vec%0d best32", k), int'(best_sad32x32), vecs[k].e_sad);
         check($sformatf("vec%0d col", k), int'(best_col[200 +: 5]), vecs[k].e_col);
         check($sformatf("vec%0d row", k), int'(best_row[280 +: 7]), vecs[k].e_row);
         check($sformatf("vec%0d result_valid", k), int'(result_valid), int'(vecs[k].e_rv));
         check($sformatf("vec%0d busy", k), int'(busy), int'(vecs[k].e_busy));
         $display("[TB] vec%0d start=%0d valid=%0d last=%0d sad=%0d -> best32=%0d rv=%0d busy=%0d",
                  k, vecs[k].start, vecs[k].valid, vecs[k].last, vecs[k].sad,
                  best_sad32x32, result_valid, busy);
      end

      // Reset leaves every lane at its all-ones width and MVs at zero
      fill_ones();
      drive(0, 0, 0, 0, 0, 0);
      exp_reset();
      check_all("reset");
      check("reset result_valid", int'(result_valid), 0);
      $display("[TB] reset: all lanes checked");

      // Only 8x8 lane 5 finds its minimum at (3,10)
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) v[i] = 100;
      drive(1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 16; i++) v[i] = (i == 5) ? 42 : 200;
      drive(1, 0, 1, 0, 3, 10);
      for (int i = 0; i < 16; i++) v[i] = (i == 5) ? 60 : 150;
      drive(1, 0, 1, 1, 1, 1);
      exp_reset();
      for (int i = 0; i < 16; i++) exp_s[i] = 100;
      exp_s[5] = 42; exp_c[5] = 3; exp_r[5] = 10;
      check_all("lane5");
      check("lane5 result_valid", int'(result_valid), 1);
      $display("[TB] lane5 sequence: lane5 sad=%0d col=%0d row=%0d",
               got_sad(5), best_col[25 +: 5], best_row[35 +: 7]);

      // Every group: even lanes improve on the last sample, odd lanes do not
      fill_ones();
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 41; i++) v[i] = 100 + i;
      drive(1, 0, 1, 0, 1, 2);
      for (int i = 0; i < 41; i++) v[i] = (i % 2 == 0) ? 50 : 200;
      drive(1, 0, 1, 1, 2, 5);
      for (int i = 0; i < 41; i++) begin
         if (i % 2 == 0) begin
            exp_s[i] = 50;  exp_c[i] = 2; exp_r[i] = 5;
         end else begin
            exp_s[i] = 100 + i; exp_c[i] = 1; exp_r[i] = 2;
         end
      end
      check_all("groups");
      check("groups result_valid", int'(result_valid), 1);
      check("groups busy", int'(busy), 0);
      $display("[TB] group sequence: lane40 sad=%0d lane39 sad=%0d", got_sad(40), got_sad(39));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
